// File: rtl/id_ex_stage.sv
// MIPS decode stage and ID/EX pipeline register.
// Drives register-file read addresses, detects load-use hazards and applies EX branch flushes.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_pc4,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_rdata1,
    input  logic [DATA_W-1:0] i_rdata2,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic              o_stall,
    output logic              o_ex_valid,
    output logic [DATA_W-1:0] o_ex_rdata1,
    output logic [DATA_W-1:0] o_ex_rdata2,
    output logic [DATA_W-1:0] o_ex_imm,
    output logic [4:0]        o_ex_rs,
    output logic [4:0]        o_ex_rt,
    output logic [4:0]        o_ex_dest,
    output logic [5:0]        o_ex_opcode,
    output logic [5:0]        o_ex_funct,
    output logic [4:0]        o_ex_shamt,
    output logic              o_ex_regwrite,
    output logic              o_ex_memread,
    output logic              o_ex_memwrite,
    output logic              o_ex_memtoreg,
    output logic              o_ex_alusrc,
    output logic              o_ex_branch,
    output logic [DATA_W-1:0] o_ex_pc4,
    output logic              o_ex_illegal,
    output logic [CNT_W-1:0]  o_stall_count
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned IMM_W = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] F_SLL = 6'h00;
    localparam logic [OP_W-1:0] F_SRL = 6'h02;
    localparam logic [OP_W-1:0] F_SRA = 6'h03;
    localparam logic [OP_W-1:0] F_JR  = 6'h08;

    logic [OP_W-1:0]   op;
    logic [OP_W-1:0]   funct;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  shamt;
    logic [IMM_W-1:0]  imm16;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_lui;

    assign op       = i_instr[31:26];
    assign o_rs     = i_instr[25:21];
    assign o_rt     = i_instr[20:16];
    assign rd       = i_instr[15:11];
    assign shamt    = i_instr[10:6];
    assign funct    = i_instr[5:0];
    assign imm16    = i_instr[15:0];
    assign imm_sext = {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};
    assign imm_zext = DATA_W'(imm16);
    assign imm_lui  = DATA_W'({imm16, 16'h0000});

    logic [DATA_W-1:0] dec_imm;
    logic [REG_W-1:0]  dec_dest;
    logic dec_regwrite, dec_memread, dec_memwrite, dec_memtoreg, dec_alusrc, dec_branch;
    logic dec_illegal, uses_rs, uses_rt;

    // Instruction decode: immediate form, destination, control bits and source usage
    always_comb begin
        dec_imm      = '0;
        dec_dest     = '0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_alusrc   = 1'b0;
        dec_branch   = 1'b0;
        dec_illegal  = 1'b0;
        uses_rs      = 1'b0;
        uses_rt      = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_dest     = rd;
                dec_regwrite = (funct != F_JR);
                uses_rs      = !(funct == F_SLL || funct == F_SRL || funct == F_SRA);
                uses_rt      = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec_imm      = imm_sext;
                dec_dest     = o_rt;
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
                uses_rs      = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_imm      = imm_zext;
                dec_dest     = o_rt;
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
                uses_rs      = 1'b1;
            end
            OP_LUI: begin
                dec_imm      = imm_lui;
                dec_dest     = o_rt;
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
            end
            OP_LW: begin
                dec_imm      = imm_sext;
                dec_dest     = o_rt;
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
                dec_memtoreg = 1'b1;
                uses_rs      = 1'b1;
            end
            OP_SW: begin
                dec_imm      = imm_sext;
                dec_dest     = o_rt;
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_imm    = imm_sext;
                dec_dest   = o_rt;
                dec_branch = 1'b1;
                uses_rs    = 1'b1;
                uses_rt    = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Writes to $zero are architecturally discarded
        if (dec_dest == '0) begin
            dec_regwrite = 1'b0;
        end
    end

    logic ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_rdata1_q, ex_rdata1_d, ex_rdata2_q, ex_rdata2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d, ex_pc4_q, ex_pc4_d;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dest_q, ex_dest_d;
    logic [REG_W-1:0] ex_shamt_q, ex_shamt_d;
    logic [OP_W-1:0] ex_opcode_q, ex_opcode_d, ex_funct_q, ex_funct_d;
    logic ex_regwrite_q, ex_regwrite_d, ex_memread_q, ex_memread_d;
    logic ex_memwrite_q, ex_memwrite_d, ex_memtoreg_q, ex_memtoreg_d;
    logic ex_alusrc_q, ex_alusrc_d, ex_branch_q, ex_branch_d;
    logic ex_illegal_q, ex_illegal_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic hz;

    assign hz = i_valid & ex_valid_q & ex_memread_q & (ex_dest_q != '0) &
                ((uses_rs & (ex_dest_q == o_rs)) | (uses_rt & (ex_dest_q == o_rt)));
    assign o_stall = hz & ~i_flush;

    // Next ID/EX contents: bubble on flush, hazard or empty IF/ID, else the decoded instruction
    always_comb begin
        ex_valid_d    = 1'b0;
        ex_rdata1_d   = '0;
        ex_rdata2_d   = '0;
        ex_imm_d      = '0;
        ex_pc4_d      = '0;
        ex_rs_d       = '0;
        ex_rt_d       = '0;
        ex_dest_d     = '0;
        ex_shamt_d    = '0;
        ex_opcode_d   = '0;
        ex_funct_d    = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        ex_memwrite_d = 1'b0;
        ex_memtoreg_d = 1'b0;
        ex_alusrc_d   = 1'b0;
        ex_branch_d   = 1'b0;
        ex_illegal_d  = 1'b0;
        stall_count_d = stall_count_q;
        if (!(i_flush || hz || !i_valid)) begin
            ex_valid_d    = 1'b1;
            ex_rdata1_d   = i_rdata1;
            ex_rdata2_d   = i_rdata2;
            ex_imm_d      = dec_imm;
            ex_pc4_d      = i_pc4;
            ex_rs_d       = o_rs;
            ex_rt_d       = o_rt;
            ex_dest_d     = dec_dest;
            ex_shamt_d    = shamt;
            ex_opcode_d   = op;
            ex_funct_d    = funct;
            ex_regwrite_d = dec_regwrite;
            ex_memread_d  = dec_memread;
            ex_memwrite_d = dec_memwrite;
            ex_memtoreg_d = dec_memtoreg;
            ex_alusrc_d   = dec_alusrc;
            ex_branch_d   = dec_branch;
            ex_illegal_d  = dec_illegal;
        end
        if (o_stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_rdata1_q   <= '0;
            ex_rdata2_q   <= '0;
            ex_imm_q      <= '0;
            ex_pc4_q      <= '0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_dest_q     <= '0;
            ex_shamt_q    <= '0;
            ex_opcode_q   <= '0;
            ex_funct_q    <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            ex_alusrc_q   <= 1'b0;
            ex_branch_q   <= 1'b0;
            ex_illegal_q  <= 1'b0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rdata1_q   <= ex_rdata1_d;
            ex_rdata2_q   <= ex_rdata2_d;
            ex_imm_q      <= ex_imm_d;
            ex_pc4_q      <= ex_pc4_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_dest_q     <= ex_dest_d;
            ex_shamt_q    <= ex_shamt_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_funct_q    <= ex_funct_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
            ex_memtoreg_q <= ex_memtoreg_d;
            ex_alusrc_q   <= ex_alusrc_d;
            ex_branch_q   <= ex_branch_d;
            ex_illegal_q  <= ex_illegal_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign o_ex_valid    = ex_valid_q;
    assign o_ex_rdata1   = ex_rdata1_q;
    assign o_ex_rdata2   = ex_rdata2_q;
    assign o_ex_imm      = ex_imm_q;
    assign o_ex_pc4      = ex_pc4_q;
    assign o_ex_rs       = ex_rs_q;
    assign o_ex_rt       = ex_rt_q;
    assign o_ex_dest     = ex_dest_q;
    assign o_ex_shamt    = ex_shamt_q;
    assign o_ex_opcode   = ex_opcode_q;
    assign o_ex_funct    = ex_funct_q;
    assign o_ex_regwrite = ex_regwrite_q;
    assign o_ex_memread  = ex_memread_q;
    assign o_ex_memwrite = ex_memwrite_q;
    assign o_ex_memtoreg = ex_memtoreg_q;
    assign o_ex_alusrc   = ex_alusrc_q;
    assign o_ex_branch   = ex_branch_q;
    assign o_ex_illegal  = ex_illegal_q;
    assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver predicts each ID/EX load, monitor compares after the edge.
module tb_id_ex_stage;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic i_valid, i_flush;
    logic [31:0] i_instr;
    logic [DATA_W-1:0] i_pc4, i_rdata1, i_rdata2;
    logic [4:0] o_rs, o_rt, o_ex_rs, o_ex_rt, o_ex_dest, o_ex_shamt;
    logic o_stall, o_ex_valid, o_ex_regwrite, o_ex_memread, o_ex_memwrite;
    logic o_ex_memtoreg, o_ex_alusrc, o_ex_branch, o_ex_illegal;
    logic [DATA_W-1:0] o_ex_rdata1, o_ex_rdata2, o_ex_imm, o_ex_pc4;
    logic [5:0] o_ex_opcode, o_ex_funct;
    logic [CNT_W-1:0] o_stall_count;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_instr(i_instr), .i_pc4(i_pc4),
        .i_flush(i_flush), .i_rdata1(i_rdata1), .i_rdata2(i_rdata2),
        .o_rs(o_rs), .o_rt(o_rt), .o_stall(o_stall), .o_ex_valid(o_ex_valid),
        .o_ex_rdata1(o_ex_rdata1), .o_ex_rdata2(o_ex_rdata2), .o_ex_imm(o_ex_imm),
        .o_ex_rs(o_ex_rs), .o_ex_rt(o_ex_rt), .o_ex_dest(o_ex_dest),
        .o_ex_opcode(o_ex_opcode), .o_ex_funct(o_ex_funct), .o_ex_shamt(o_ex_shamt),
        .o_ex_regwrite(o_ex_regwrite), .o_ex_memread(o_ex_memread),
        .o_ex_memwrite(o_ex_memwrite), .o_ex_memtoreg(o_ex_memtoreg),
        .o_ex_alusrc(o_ex_alusrc), .o_ex_branch(o_ex_branch), .o_ex_pc4(o_ex_pc4),
        .o_ex_illegal(o_ex_illegal), .o_stall_count(o_stall_count)
    );

    // Register file model: written on the falling edge, read combinationally
    logic [31:0] rf [32];
    assign i_rdata1 = rf[o_rs];
    assign i_rdata2 = rf[o_rt];

    typedef struct {
        logic        valid;
        logic [31:0] rdata1, rdata2, imm, pc4;
        logic [4:0]  rs, rt, dest, shamt;
        logic [5:0]  opcode, funct;
        logic        regwrite, memread, memwrite, memtoreg, alusrc, branch, illegal;
        logic        chk_dest, chk_imm, chk_alusrc;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int unsigned cnt_m;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] pc = 32'h0040_0004;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.valid = 0; e.rdata1 = 0; e.rdata2 = 0; e.imm = 0; e.pc4 = 0;
        e.rs = 0; e.rt = 0; e.dest = 0; e.shamt = 0; e.opcode = 0; e.funct = 0;
        e.regwrite = 0; e.memread = 0; e.memwrite = 0; e.memtoreg = 0;
        e.alusrc = 0; e.branch = 0; e.illegal = 0;
        e.chk_dest = 1; e.chk_imm = 1; e.chk_alusrc = 1; e.cnt = 0;
        return e;
    endfunction

    // Reference decode, by instruction class
    function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] p4);
        exp_t e = bubble();
        logic [15:0] imm = ins[15:0];
        e.valid = 1; e.pc4 = p4;
        e.rs = ins[25:21]; e.rt = ins[20:16]; e.shamt = ins[10:6];
        e.opcode = ins[31:26]; e.funct = ins[5:0];
        e.rdata1 = rf[e.rs]; e.rdata2 = rf[e.rt];
        case (e.opcode)
            6'h00: begin e.dest = ins[15:11]; e.regwrite = (e.funct != 6'h08); e.chk_imm = 0; end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                e.imm = 32'($signed(imm)); e.dest = e.rt; e.alusrc = 1; e.regwrite = 1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                e.imm = 32'(imm); e.dest = e.rt; e.alusrc = 1; e.regwrite = 1;
            end
            6'h0F: begin e.imm = 32'(imm) * 32'h10000; e.dest = e.rt; e.regwrite = 1; e.chk_alusrc = 0; end
            6'h23: begin
                e.imm = 32'($signed(imm)); e.dest = e.rt; e.alusrc = 1; e.regwrite = 1;
                e.memread = 1; e.memtoreg = 1;
            end
            6'h2B: begin e.imm = 32'($signed(imm)); e.alusrc = 1; e.memwrite = 1; e.chk_dest = 0; end
            6'h04, 6'h05: begin e.imm = 32'($signed(imm)); e.branch = 1; e.chk_dest = 0; end
            default: begin e.illegal = 1; e.chk_dest = 0; e.chk_imm = 0; end
        endcase
        if (e.dest == 0) e.regwrite = 0;
        return e;
    endfunction

    // Does the instruction read register r (for load-use purposes)?
    function automatic logic reads(input logic [31:0] ins, input logic [4:0] r);
        logic rs_hit = (ins[25:21] == r);
        logic rt_hit = (ins[20:16] == r);
        case (ins[31:26])
            6'h00: return rt_hit || (rs_hit && !(ins[5:0] inside {6'h00, 6'h02, 6'h03}));
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23: return rs_hit;
            6'h2B, 6'h04, 6'h05: return rs_hit || rt_hit;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    task automatic cycle(input logic v, input logic [31:0] ins, input logic fl,
                         input logic wb, input logic [4:0] wr, input logic [31:0] wv,
                         output logic st);
        exp_t e;
        logic hz;
        @(negedge clk);
        rst_n = 1'b1;
        if (wb && wr != 0) rf[wr] = wv;
        i_valid = v; i_instr = ins; i_pc4 = pc; i_flush = fl;
        #1;
        hz = v && last.valid && last.memread && (last.dest != 0) && reads(ins, last.dest);
        st = hz && !fl;
        chk("o_stall", 32'(o_stall), 32'(st));
        chk("o_rs", 32'(o_rs), 32'(ins[25:21]));
        chk("o_rt", 32'(o_rt), 32'(ins[20:16]));
        e = (fl || hz || !v) ? bubble() : predict(ins, pc);
        if (st && cnt_m < CNT_MAX) cnt_m++;
        e.cnt = cnt_m;
        q.push_back(e);
        last = e;
    endtask

    // Present one IF/ID instruction, holding it while the front end is stalled
    task automatic issue(input logic v, input logic [31:0] ins, input logic fl, input logic rnd_fl,
                         input logic wb, input logic [4:0] wr, input logic [31:0] wv);
        logic st;
        logic f = fl;
        logic w = wb;
        int n = 0;
        do begin
            cycle(v, ins, f, w, wr, wv, st);
            w = 0; n++;
            if (rnd_fl) f = ($urandom_range(0, 9) == 0);
        end while (st && n < 4);
        pc += 4;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_valid"}, 32'(o_ex_valid), 0);
        chk({tag, "_regwrite"}, 32'(o_ex_regwrite), 0);
        chk({tag, "_memread"}, 32'(o_ex_memread), 0);
        chk({tag, "_alusrc"}, 32'(o_ex_alusrc), 0);
        chk({tag, "_imm"}, o_ex_imm, 0);
        chk({tag, "_dest"}, 32'(o_ex_dest), 0);
        chk({tag, "_rdata1"}, o_ex_rdata1, 0);
        chk({tag, "_pc4"}, o_ex_pc4, 0);
        chk({tag, "_illegal"}, 32'(o_ex_illegal), 0);
        chk({tag, "_stall"}, 32'(o_stall), 0);
        chk({tag, "_cnt"}, 32'(o_stall_count), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_valid = 1'b1; i_instr = enc_i(8, 0, 8, 5); i_flush = 1'b0;
        #1 reset_check("rst_async");
        @(posedge clk);
        #2 reset_check("rst_hold");
        last = bubble();
        cnt_m = 0;
    endtask

    // Monitor: pop and compare after every active edge with a prediction pending
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", 32'(o_ex_valid), 32'(e.valid));
                chk("ex_rdata1", o_ex_rdata1, e.rdata1);
                chk("ex_rdata2", o_ex_rdata2, e.rdata2);
                chk("ex_rs", 32'(o_ex_rs), 32'(e.rs));
                chk("ex_rt", 32'(o_ex_rt), 32'(e.rt));
                chk("ex_shamt", 32'(o_ex_shamt), 32'(e.shamt));
                chk("ex_opcode", 32'(o_ex_opcode), 32'(e.opcode));
                chk("ex_funct", 32'(o_ex_funct), 32'(e.funct));
                chk("ex_pc4", o_ex_pc4, e.pc4);
                chk("ex_regwrite", 32'(o_ex_regwrite), 32'(e.regwrite));
                chk("ex_memread", 32'(o_ex_memread), 32'(e.memread));
                chk("ex_memwrite", 32'(o_ex_memwrite), 32'(e.memwrite));
                chk("ex_memtoreg", 32'(o_ex_memtoreg), 32'(e.memtoreg));
                chk("ex_branch", 32'(o_ex_branch), 32'(e.branch));
                chk("ex_illegal", 32'(o_ex_illegal), 32'(e.illegal));
                chk("stall_count", 32'(o_stall_count), e.cnt);
                if (e.chk_dest) chk("ex_dest", 32'(o_ex_dest), 32'(e.dest));
                if (e.chk_imm) chk("ex_imm", o_ex_imm, e.imm);
                if (e.chk_alusrc) chk("ex_alusrc", 32'(o_ex_alusrc), 32'(e.alusrc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    logic [5:0] fn_tab [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h2B, 6'h08, 6'h00, 6'h02, 6'h03};
    logic [5:0] bad_tab [5] = '{6'h01, 6'h02, 6'h03, 6'h20, 6'h3F};

    function automatic int rreg();
        int pick = int'($urandom_range(0, 5));
        case (pick)
            0: return 0;
            1, 2, 3, 4: return 8 + pick - 1;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        int sel = int'($urandom_range(0, 11));
        int imm = int'($urandom_range(0, 65535));
        case (sel)
            0, 1, 2, 3: return enc_r(rreg(), rreg(), rreg(), int'($urandom_range(0, 31)),
                                     int'(fn_tab[$urandom_range(0, 13)]));
            4: return enc_i(8 + int'($urandom_range(0, 3)), rreg(), rreg(), imm);
            5: return enc_i(12 + int'($urandom_range(0, 2)), rreg(), rreg(), imm);
            6: return enc_i(15, 0, rreg(), imm);
            7, 8: return enc_i(35, rreg(), rreg(), imm);
            9: return enc_i(43, rreg(), rreg(), imm);
            10: return enc_i(4 + int'($urandom_range(0, 1)), rreg(), rreg(), imm);
            default: return enc_i(int'(bad_tab[$urandom_range(0, 4)]), rreg(), rreg(), imm);
        endcase
    endfunction

    initial begin
        rf[0] = 0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        last = bubble();
        cnt_m = 0;
        rst_n = 1'b0;
        i_valid = 1'b1; i_instr = enc_i(8, 0, 8, 5); i_pc4 = 32'h10; i_flush = 1'b0;
        #1 reset_check("rst_init");
        repeat (2) @(posedge clk);
        #2 reset_check("rst_init_hold");

        issue(1, enc_i(8, 0, 8, 5), 0, 0, 0, 0, 0);          // addi $t0,$zero,5
        issue(1, enc_i(12, 9, 9, 16'hFFFF), 0, 0, 0, 0, 0);  // andi zero-extends
        issue(1, enc_i(8, 9, 10, 16'hFFFF), 0, 0, 0, 0, 0);  // addi sign-extends
        issue(1, enc_i(15, 0, 11, 16'h1234), 0, 0, 0, 0, 0); // lui
        issue(1, enc_i(35, 9, 8, 0), 0, 0, 0, 0, 0);         // lw $t0,0($t1)
        issue(1, enc_r(8, 11, 10, 0, 6'h20), 0, 0, 0, 0, 0); // add $t2,$t0,$t3 stalls
        issue(1, enc_i(35, 9, 8, 0), 0, 0, 0, 0, 0);
        issue(1, enc_r(0, 8, 10, 2, 6'h00), 0, 0, 0, 0, 0);  // sll $t2,$t0,2 stalls on rt
        issue(1, enc_i(35, 9, 8, 0), 0, 0, 0, 0, 0);
        issue(1, enc_i(15, 0, 8, 16'h00AB), 0, 0, 0, 0, 0);  // lui consumer: no stall
        issue(1, enc_i(35, 9, 8, 0), 0, 0, 0, 0, 0);
        issue(1, enc_r(8, 11, 10, 0, 6'h20), 1, 0, 0, 0, 0); // flush beats hazard
        issue(1, enc_i(8, 9, 10, 1), 0, 0, 1, 9, 32'hDEADBEEF); // same-cycle writeback visible
        issue(1, enc_i(6'h3F, 8, 9, 16'h1111), 0, 0, 0, 0, 0); // illegal opcode
        issue(1, enc_r(8, 9, 0, 0, 6'h20), 0, 0, 0, 0, 0);   // add $zero: regwrite dropped
        issue(1, enc_r(8, 0, 0, 0, 6'h08), 0, 0, 0, 0, 0);   // jr
        issue(0, enc_i(8, 0, 8, 5), 0, 0, 0, 0, 0);          // empty IF/ID

        for (int i = 0; i < 18; i++) begin                   // drive the counter into saturation
            issue(1, enc_i(35, 9, 8, 4), 0, 0, 0, 0, 0);
            issue(1, enc_r(8, 11, 10, 0, 6'h20), 0, 0, 0, 0, 0);
        end

        do_reset();
        issue(1, enc_i(8, 0, 8, 5), 0, 0, 0, 0, 0);          // first edge after release captures

        for (int i = 0; i < 800; i++) begin
            issue($urandom_range(0, 9) != 0, rand_instr(), $urandom_range(0, 9) == 0, 1,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
            if (i == 400) do_reset();
        end

        issue(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage plus ID/EX pipeline register of the MIPS datapath. It drives the register file read addresses from the instruction held in IF/ID and captures the returned operands, the extended immediate and the control bits into ID/EX for the execute stage. It also detects load-use hazards, stalling the front end and injecting a bubble, and it honours branch flushes from EX.

## Interface
- DATA_W, 32, operand/PC width
- CNT_W, 16, width of stall performance counter

- Clock  in  1  rising-edge clock for ID/EX; register file writes on falling edge
- Reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  IF/ID holds a valid instruction
- i_instr  in  32  IF/ID instruction
- i_pc4  in  DATA_W  IF/ID PC+4
- i_flush  in  1  branch taken in EX; kill instruction in ID
- i_rdata1, i_rdata2  in  DATA_W  register file ReadData1/ReadData2
- o_rs, o_rt  out  5  register file ReadRegister1/ReadRegister2 (combinational = instr[25:21], instr[20:16])
- o_stall  out  1  combinational; freeze PC and IF/ID this cycle
- o_ex_valid  out  1  ID/EX holds a real instruction
- o_ex_rdata1, o_ex_rdata2  out  DATA_W  captured operands
- o_ex_imm  out  DATA_W  extended immediate
- o_ex_rs, o_ex_rt, o_ex_dest  out  5  source fields; resolved destination register
- o_ex_opcode, o_ex_funct  out  6  raw fields for ALU control
- o_ex_shamt  out  5  shift amount
- o_ex_regwrite, o_ex_memread, o_ex_memwrite, o_ex_memtoreg, o_ex_alusrc, o_ex_branch  out  1  control bits
- o_ex_pc4  out  DATA_W  captured PC+4
- o_ex_illegal  out  1  unsupported opcode captured
- o_stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Supported decode:
  - R-type (opcode 0): regwrite=1, dest=rd, alusrc=0. If funct is jr (0x08), regwrite=0.
  - addi/addiu/slti/sltiu: sign-extended immediate, dest=rt, alusrc=1, regwrite=1.
  - andi/ori/xori: zero-extended immediate; otherwise same as addi.
  - lui: immediate = imm<<16, regwrite=1, dest=rt.
  - lw: memread=1, memtoreg=1, regwrite=1, alusrc=1, sign-extended immediate, dest=rt.
  - sw: memwrite=1, alusrc=1, sign-extended immediate, regwrite=0.
  - beq/bne: branch=1, sign-extended immediate, alusrc=0, regwrite=0.
- Any other opcode: all control bits 0 and o_ex_illegal=1, but o_ex_valid=1 so the fault reaches EX.
- Dest register 0 with regwrite=1: regwrite is forced to 0.
- Source usage for hazard checks:
  - rs is used by all supported opcodes except lui.
  - rt is used by R-type, sw, beq and bne.
  - R-type sll/srl/sra (funct 0x00/0x02/0x03) do not use rs.
- Load-use hazard: hz = i_valid & o_ex_valid & o_ex_memread & (o_ex_dest!=0) & ((uses_rs & o_ex_dest==o_rs) | (uses_rt & o_ex_dest==o_rt)).
- o_stall = hz & ~i_flush.
- At each rising edge, in priority order:
  1. Reset.
  2. i_flush or hz or ~i_valid: load a bubble (o_ex_valid=0, all control bits and o_ex_illegal=0; data fields don't-care but held at 0).
  3. Otherwise capture the decoded instruction.
- o_stall_count increments on each cycle with o_stall=1 and saturates at all-ones.

## Timing
- Reset (Reset_n low, asynchronous): every registered output is 0, including o_stall_count. o_stall is 0 because o_ex_valid=0.
- Latency: one cycle from IF/ID to ID/EX.
- Register file writes on the falling edge, so a WB write in cycle N is visible in i_rdata at the rising edge ending cycle N. No WB bypass is needed here.
- A load-use stall lasts exactly one cycle; the bubble clears the hazard on the next cycle.
- Flush and hazard together: flush wins, o_stall=0, bubble loaded.
- Reset deasserted mid-stream: first edge after release captures normally.

## Test plan
- Reset: hold Reset_n=0 with i_valid=1 and instr=addi $t0,$zero,5 -> all outputs 0. Release -> next edge gives o_ex_valid=1, o_ex_imm=5, o_ex_dest=8, regwrite=1, alusrc=1.
- Extension: andi with imm 0xFFFF -> o_ex_imm=0x0000FFFF. addi with imm 0xFFFF -> 0xFFFFFFFF. lui with imm 0x1234 -> 0x12340000.
- Load-use: lw $t0,0($t1) then add $t2,$t0,$t3 -> o_stall=1 for one cycle, one bubble, add captured the following cycle, o_stall_count=1. Repeat with sll $t2,$t0,2 -> stall (rt used). With lui $t0 as consumer -> no stall.
- Flush: assert i_flush during a load-use hazard -> o_stall=0, ID/EX bubble, o_stall_count unchanged.
- Writeback visibility: register file write of 0xDEADBEEF to r9 in the same cycle an instruction reads r9 -> o_ex_rdata1=0xDEADBEEF.
- Illegal/zero dest: opcode 0x3F -> o_ex_illegal=1, controls 0. add $zero,$t0,$t1 -> o_ex_regwrite=0.
